// File: rtl/ssp_uart_clk_pkg.sv
// Shared constants for the SSP/UART NCO clock synthesiser and a helper that turns
// a target frequency into a phase increment for benches and firmware tables.
package ssp_uart_clk_pkg;

  localparam int NUM_CH_DEF      = 4;
  localparam int ACC_W_DEF       = 32;
  localparam int LOCK_CYCLES_DEF = 1024;
  localparam longint unsigned REFCLK_HZ = 64'd48_000_000;

  // round(hz * 2^acc_w / REFCLK_HZ) by shift-subtract division, so wide
  // accumulators never overflow the 64-bit intermediate.
  function automatic longint unsigned nco_inc(input longint unsigned hz,
                                              input int acc_w = ACC_W_DEF);
    longint unsigned quot;
    longint unsigned rem;
    quot = hz / REFCLK_HZ;
    rem  = hz % REFCLK_HZ;
    for (int i = 0; i < acc_w; i++) begin
      quot = quot << 1;
      rem  = rem << 1;
      if (rem >= REFCLK_HZ) begin
        rem  = rem - REFCLK_HZ;
        quot = quot | 64'd1;
      end
    end
    if ((rem << 1) >= REFCLK_HZ) quot = quot + 64'd1;
    return quot;
  endfunction

endpackage

// File: rtl/ssp_uart_nco_ch.sv
// One NCO channel: phase accumulator, inc/phase config registers and lock counter.
// Tick and square wave are registered, visible the cycle after the wrapping add.
module ssp_uart_nco_ch
  import ssp_uart_clk_pkg::*;
#(
  parameter int ACC_W       = ACC_W_DEF,
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [ACC_W-1:0] wr_inc,
  input  logic [ACC_W-1:0] wr_phase,
  input  logic             en,
  input  logic             sync,
  output logic             tick,
  output logic             wave,
  output logic             ch_locked
);

  localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_CYCLES);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic [ACC_W-1:0] phase;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] load_phase;

  // A write coinciding with sync or disable loads the freshly written phase.
  always_comb begin
    sum        = {1'b0, acc} + {1'b0, inc};
    load_phase = wr ? wr_phase : phase;
    cnt_nxt    = cnt;
    if (!en || wr) begin
      cnt_nxt = '0;
    end else if (inc != '0 && cnt != LOCK_MAX) begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc       <= '0;
      inc       <= '0;
      phase     <= '0;
      cnt       <= '0;
      tick      <= 1'b0;
      wave      <= 1'b0;
      ch_locked <= 1'b0;
    end else begin
      if (wr) begin
        inc   <= wr_inc;
        phase <= wr_phase;
      end
      cnt       <= cnt_nxt;
      ch_locked <= (cnt_nxt == LOCK_MAX);
      if (!en) begin
        acc  <= load_phase;
        tick <= 1'b0;
        wave <= 1'b0;
      end else if (sync) begin
        acc  <= load_phase;
        tick <= 1'b0;
        wave <= load_phase[ACC_W-1];
      end else begin
        acc  <= sum[ACC_W-1:0];
        tick <= sum[ACC_W];
        wave <= sum[ACC_W-1];
      end
    end
  end

endmodule

// File: rtl/ssp_uart_clk_nco.sv
// Multi-channel NCO clock synthesiser off the 48 MHz refclk: per-channel ticks, square
// waves and lock flags, plus a global locked flag registered one cycle after ch_locked.
module ssp_uart_clk_nco
  import ssp_uart_clk_pkg::*;
#(
  parameter int NUM_CH      = NUM_CH_DEF,
  parameter int ACC_W       = ACC_W_DEF,
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [ACC_W-1:0]  cfg_inc,
  input  logic [ACC_W-1:0]  cfg_phase,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync,
  output logic [NUM_CH-1:0] clk_en,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] ch_locked,
  output logic              locked
);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic wr_hit;
    // Unused channel codes (cfg_ch >= NUM_CH) never match, so such writes drop.
    assign wr_hit = cfg_wr && (cfg_ch == CH_W'(c));

    ssp_uart_nco_ch #(
      .ACC_W       (ACC_W),
      .LOCK_CYCLES (LOCK_CYCLES)
    ) u_ch (
      .clk       (refclk),
      .rst       (rst),
      .wr        (wr_hit),
      .wr_inc    (cfg_inc),
      .wr_phase  (cfg_phase),
      .en        (ch_en[c]),
      .sync      (sync),
      .tick      (clk_en[c]),
      .wave      (clk_out[c]),
      .ch_locked (ch_locked[c])
    );
  end

  always_ff @(posedge refclk) begin
    if (!rst) begin
      locked <= 1'b0;
    end else begin
      locked <= (&(ch_locked | ~ch_en)) & (|ch_en);
    end
  end

endmodule

// File: tb/tb_ssp_uart_clk_nco.sv
// Scoreboarded bench: driver pushes model outputs per cycle, monitor pops and compares.
module tb_ssp_uart_clk_nco;
  import ssp_uart_clk_pkg::*;

  localparam int NCH = 3;
  localparam int W   = 8;
  localparam int LCK = 16;
  localparam longint MOD = 64'd1 << W;

  typedef struct packed {
    logic [NCH-1:0] ce;
    logic [NCH-1:0] co;
    logic [NCH-1:0] lk;
    logic           l;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           a_rst = 1'b0, a_wr = 1'b0, a_sync = 1'b0;
  logic [1:0]     a_ch = '0;
  logic [W-1:0]   a_inc = '0, a_ph = '0;
  logic [NCH-1:0] a_en = '0;
  logic [NCH-1:0] a_clk_en, a_clk_out, a_ch_locked;
  logic           a_locked;

  logic        b_rst = 1'b0, b_wr = 1'b0, b_sync = 1'b0;
  logic [0:0]  b_ch = '0, b_en = '0;
  logic [31:0] b_inc = '0, b_ph = '0;
  logic [0:0]  b_clk_en, b_clk_out, b_ch_locked;
  logic        b_locked;

  ssp_uart_clk_nco #(.NUM_CH(NCH), .ACC_W(W), .LOCK_CYCLES(LCK)) dut_a (
    .refclk(clk), .rst(a_rst), .cfg_wr(a_wr), .cfg_ch(a_ch), .cfg_inc(a_inc),
    .cfg_phase(a_ph), .ch_en(a_en), .sync(a_sync), .clk_en(a_clk_en),
    .clk_out(a_clk_out), .ch_locked(a_ch_locked), .locked(a_locked));

  ssp_uart_clk_nco #(.NUM_CH(1), .ACC_W(32), .LOCK_CYCLES(4)) dut_b (
    .refclk(clk), .rst(b_rst), .cfg_wr(b_wr), .cfg_ch(b_ch), .cfg_inc(b_inc),
    .cfg_phase(b_ph), .ch_en(b_en), .sync(b_sync), .clk_en(b_clk_en),
    .clk_out(b_clk_out), .ch_locked(b_ch_locked), .locked(b_locked));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model: accumulator kept as an integer, carry is "sum reached 2^W".
  longint m_acc[NCH], m_inc[NCH], m_ph[NCH];
  int     m_cnt[NCH];
  logic [NCH-1:0] m_lk;
  logic   m_locked;
  exp_t   exp_q[$];

  function automatic exp_t model_step(input logic r, w, input int ch, input longint inc,
                                      input longint ph, input logic [NCH-1:0] en, input logic s);
    exp_t e;
    logic [NCH-1:0] lk_old;
    logic all_ok;
    e = '0;
    if (!r) begin
      for (int c = 0; c < NCH; c++) begin
        m_acc[c] = 0; m_inc[c] = 0; m_ph[c] = 0; m_cnt[c] = 0;
      end
      m_lk = '0; m_locked = 1'b0;
      return e;
    end
    lk_old = m_lk;
    for (int c = 0; c < NCH; c++) begin
      logic hit;
      longint ld, sum;
      hit = w && (ch == c);
      ld  = hit ? ph : m_ph[c];
      if (!en[c]) begin
        m_acc[c] = ld;
        m_cnt[c] = 0;
      end else begin
        if (s) begin
          m_acc[c] = ld;
        end else begin
          sum = m_acc[c] + m_inc[c];
          e.ce[c] = (sum >= MOD);
          m_acc[c] = sum % MOD;
        end
        e.co[c] = (m_acc[c] >= MOD / 2);
        if (hit) m_cnt[c] = 0;
        else if (m_inc[c] != 0 && m_cnt[c] < LCK) m_cnt[c]++;
      end
      m_lk[c] = (m_cnt[c] == LCK);
      if (hit) begin
        m_inc[c] = inc;
        m_ph[c]  = ph;
      end
    end
    all_ok = 1'b1;
    for (int c = 0; c < NCH; c++) if (en[c] && !lk_old[c]) all_ok = 1'b0;
    m_locked = all_ok && (en != '0);
    e.lk = m_lk;
    e.l  = m_locked;
    return e;
  endfunction

  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk("outputs", 64'({a_clk_en, a_clk_out, a_ch_locked, a_locked}), 64'(mon_e));
    end
  end

  task automatic cyc(input logic r, w, input logic [1:0] ch, input logic [W-1:0] inc, ph,
                     input logic [NCH-1:0] en, input logic s);
    @(negedge clk);
    a_rst = r; a_wr = w; a_ch = ch; a_inc = inc; a_ph = ph; a_en = en; a_sync = s;
    exp_q.push_back(model_step(r, w, int'(ch), longint'(inc), longint'(ph), en, s));
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input logic [NCH-1:0] en, input int n);
    repeat (n) cyc(1'b1, 1'b0, 2'd0, 8'd0, 8'd0, en, 1'b0);
  endtask

  int ticks, highs, bad_gap, last_t, lk_first, l_first, t0[$], t1[$], pairs;
  logic [NCH-1:0] rnd_en;

  initial begin
    chk("nco_inc_uart", longint'(nco_inc(64'd1_843_200, 32)), 64'd164926744);
    chk("nco_inc_quarter", longint'(nco_inc(64'd12_000_000, 8)), 64'd64);

    // Reset with all channels enabled
    repeat (3) cyc(1'b0, 1'b1, 2'd0, 8'd55, 8'd66, 3'b111, 1'b0);
    chk("rst_outputs", 64'({a_clk_en, a_clk_out, a_ch_locked, a_locked}), 0);
    chk("rst_acc0", 64'(dut_a.g_ch[0].u_ch.acc), 0);
    chk("rst_acc2", 64'(dut_a.g_ch[2].u_ch.acc), 0);

    // Rate: inc=64 on an 8-bit accumulator
    cyc(1'b1, 1'b1, 2'd0, 8'd64, 8'd0, 3'b000, 1'b0);
    ticks = 0; highs = 0; bad_gap = 0; last_t = 0;
    for (int i = 1; i <= 100; i++) begin
      idle(3'b001, 1);
      if (a_clk_en[0]) begin
        ticks++;
        if (i - last_t != 4) bad_gap++;
        last_t = i;
      end
      if (a_clk_out[0]) highs++;
    end
    chk("rate_ticks", ticks, 25);
    chk("rate_high_cycles", highs, 50);
    chk("rate_tick_gaps_off", bad_gap, 0);

    // Sync: ch1 starts half a turn ahead of ch0
    cyc(1'b1, 1'b1, 2'd1, 8'd64, 8'd128, 3'b001, 1'b0);
    idle(3'b011, 3);
    cyc(1'b1, 1'b0, 2'd0, 8'd0, 8'd0, 3'b011, 1'b1);
    chk("sync_no_tick", 64'(a_clk_en[1:0]), 0);
    t0.delete(); t1.delete();
    for (int i = 1; i <= 16; i++) begin
      idle(3'b011, 1);
      if (a_clk_en[0]) t0.push_back(i);
      if (a_clk_en[1]) t1.push_back(i);
    end
    pairs = 0;
    foreach (t0[k]) foreach (t1[j]) if (t1[j] == t0[k] - 2) pairs++;
    chk("sync_ch0_ticks", t0.size(), 4);
    chk("sync_ch1_leads_by_2", pairs, 4);

    // Lock timing
    idle(3'b000, 2);
    cyc(1'b1, 1'b1, 2'd0, 8'd10, 8'd0, 3'b001, 1'b0);
    lk_first = -1; l_first = -1;
    for (int i = 1; i <= 40; i++) begin
      idle(3'b001, 1);
      if (lk_first < 0 && a_ch_locked[0]) lk_first = i;
      if (l_first < 0 && a_locked) l_first = i;
    end
    chk("lock_ch_cycles", lk_first, 16);
    chk("lock_global_cycles", l_first, 17);
    cyc(1'b1, 1'b1, 2'd0, 8'd10, 8'd0, 3'b001, 1'b0);
    chk("relock_ch_drop", 64'(a_ch_locked[0]), 0);
    lk_first = -1;
    for (int i = 1; i <= 40; i++) begin
      idle(3'b001, 1);
      if (i == 1) chk("relock_global_drop", 64'(a_locked), 0);
      if (lk_first < 0 && a_ch_locked[0]) lk_first = i;
    end
    chk("relock_ch_cycles", lk_first, 16);

    // Corners
    cyc(1'b1, 1'b1, 2'd3, 8'd77, 8'd99, 3'b001, 1'b0);
    chk("badch_inc0", 64'(dut_a.g_ch[0].u_ch.inc), 10);
    chk("badch_inc1", 64'(dut_a.g_ch[1].u_ch.inc), 64);
    chk("badch_inc2", 64'(dut_a.g_ch[2].u_ch.inc), 0);
    ticks = 0; lk_first = 0;
    for (int i = 0; i < 20; i++) begin
      idle(3'b100, 1);
      if (a_clk_en[2]) ticks++;
      if (a_ch_locked[2] || a_locked) lk_first++;
    end
    chk("inc0_ticks", ticks, 0);
    chk("inc0_locked_cycles", lk_first, 0);
    idle(3'b001, 3);
    cyc(1'b1, 1'b1, 2'd0, 8'd10, 8'hA5, 3'b001, 1'b1);
    chk("syncwr_acc", 64'(dut_a.g_ch[0].u_ch.acc), 64'hA5);
    chk("syncwr_clk_out", 64'(a_clk_out[0]), 1);
    cyc(1'b1, 1'b1, 2'd1, 8'd37, 8'd3, 3'b111, 1'b0);
    idle(3'b111, 9);
    cyc(1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 3'b111, 1'b0);
    chk("midrst_outputs", 64'({a_clk_en, a_clk_out, a_ch_locked, a_locked}), 0);
    chk("midrst_acc1", 64'(dut_a.g_ch[1].u_ch.acc), 0);

    // Randomised traffic against the model
    rnd_en = 3'b111;
    for (int i = 0; i < 3000; i++) begin
      logic r, w, s;
      logic [7:0] inc;
      int bit_i;
      r = ($urandom_range(0, 199) != 0);
      w = ($urandom_range(0, 5) == 0);
      s = ($urandom_range(0, 19) == 0);
      inc = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) begin
        bit_i = $urandom_range(0, NCH - 1);
        rnd_en[bit_i] = ~rnd_en[bit_i];
      end
      cyc(r, w, 2'($urandom_range(0, 3)), inc, 8'($urandom_range(0, 255)), rnd_en, s);
    end

    // Fractional rate: 1.8432 MHz from 48 MHz on a 32-bit accumulator
    @(negedge clk);
    b_rst = 1'b0;
    @(negedge clk);
    b_rst = 1'b1; b_wr = 1'b1; b_inc = 32'(nco_inc(64'd1_843_200, 32)); b_ph = '0; b_en = 1'b0;
    @(negedge clk);
    b_wr = 1'b0; b_en = 1'b1;
    ticks = 0;
    for (int i = 0; i < 40000; i++) begin
      @(posedge clk);
      #1;
      if (b_clk_en[0]) ticks++;
    end
    begin
      longint exp_t_cnt;
      exp_t_cnt = (longint'(40000) * longint'(164926744)) >>> 32;
      n_chk++;
      if (ticks >= exp_t_cnt - 1 && ticks <= exp_t_cnt + 1) n_pass++;
      else $display("FAIL frac_ticks: got %0d expected %0d +/-1", ticks, exp_t_cnt);
    end
    chk("frac_ch_locked", 64'(b_ch_locked[0]), 1);
    chk("frac_locked", 64'(b_locked), 1);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
